instr_fetch: RTL and testbench
==============================

# instr_fetch

Sequential instruction-fetch front end for the MIPS core. It owns the program counter and issues word requests to instruction memory over a valid/ready request channel. It registers each returned word and presents the instruction and its `opcode` field to the control decoder and the datapath. It also applies taken-branch redirects, discarding any fetch that is already in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `imem_req_valid` output 1: a fetch request is presented.
- `imem_req_ready` input 1: memory accepts the request. Handshake = valid && ready.
- `imem_req_addr` output 32: byte address of the word to fetch. Always word-aligned.
- `imem_rsp_valid` input 1: one-cycle pulse; `imem_rsp_data` is valid this cycle.
- `imem_rsp_data` input 32: fetched instruction word.
- `branch_taken` input 1: redirect request, from Branch && zero.
- `branch_target` input 32: redirect address. Bits [1:0] are ignored and forced to 0.
- `stall` input 1: downstream cannot consume the held instruction.
- `instr_valid` output 1: `instr` holds a valid instruction.
- `instr` output 32: registered instruction word.
- `opcode` output 6: `instr[31:26]`, combinational from the register; drives the control decoder.
- `instr_pc` output 32: address `instr` was fetched from.
- `pc_plus4` output 32: `instr_pc + 4`, modulo 2^32.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - Output slot: `instr`, `instr_pc`, `instr_valid`.
  - `req_pc`: address of the outstanding request.
  - FSM state.
- At most one request is outstanding at any time.
- Consumption: the slot is consumed in any cycle with `instr_valid && !stall`.
- FSM states:
  - FETCH:
    - `imem_req_valid = (!instr_valid || !stall)`, with `imem_req_addr = pc`.
    - On handshake: `req_pc <= pc`, `pc <= pc + 4` (wraps 32'hFFFF_FFFC -> 0), go to WAIT.
  - WAIT:
    - `imem_req_valid = 0`.
    - On `imem_rsp_valid`: `instr <= imem_rsp_data`, `instr_pc <= req_pc`, `instr_valid <= 1`, go to FETCH.
  - DISCARD:
    - `imem_req_valid = 0`.
    - On `imem_rsp_valid`: drop the data, leave the slot untouched, go to FETCH.
- `instr_valid` clears when the slot is consumed and not refilled in the same cycle.
- Redirect (`branch_taken = 1`) has priority over everything else:
  - `pc <= {branch_target[31:2], 2'b00}`.
  - `instr_valid <= 0` (flush), regardless of `stall`.
  - From FETCH with a handshake in the same cycle: the request is still issued to memory at the old `pc`; go to DISCARD.
  - From FETCH with no handshake: stay in FETCH.
  - From WAIT with no response this cycle: go to DISCARD.
  - From WAIT with a response this cycle: drop the response, go to FETCH.
  - From DISCARD: stay in DISCARD until the pending response arrives.
- Any `imem_rsp_valid` received in FETCH is ignored. Memory must never generate this; the bench flags it.
- `stall` never blocks a redirect and never drops a held instruction.

## Timing
- Reset, while `rst_n = 0` at a clock edge:
  - `pc = RESET_PC`, state = FETCH.
  - `instr_valid = 0`, `instr = 0` (so `opcode = 0`).
  - `instr_pc = 0`, `pc_plus4 = 4`, `req_pc = 0`.
  - `imem_req_valid` is forced to 0 while `rst_n = 0`.
- First request: `imem_req_valid = 1` with `imem_req_addr = RESET_PC` in the first cycle after `rst_n` rises.
- Latency: response in cycle t -> `instr_valid = 1` in cycle t+1.
- Throughput: with a 1-cycle memory and no stall, one instruction every 2 cycles.
  - The next request issues in the same cycle the held instruction is consumed.
- Reset asserted mid-fetch (WAIT or DISCARD): the FSM returns to FETCH and any later stray response is ignored. The memory model must also be reset.
- `imem_req_addr` and `imem_req_valid` stay stable while valid && !ready, unless a redirect occurs. On a redirect without handshake, the address changes to the target on the next cycle.

## Test plan
- Reset and sequential fetch:
  - Stimulus: `RESET_PC = 0`, 1-cycle memory, no stall; release reset.
  - Required: requests at 0x0, 0x4, 0x8. `instr_valid` pulses every 2nd cycle. `instr_pc` / `pc_plus4` = 0/4, 4/8, 8/12. `opcode` matches the word, e.g. 0x8C..._.... -> 6'b100011.
- Backpressure on both sides:
  - Stimulus: hold `imem_req_ready = 0` for 3 cycles; then hold `stall = 1` for 4 cycles with `instr_valid = 1`.
  - Required: address stays stable while not ready. `instr` holds, no new request is issued, and nothing is lost.
- Redirect in WAIT:
  - Stimulus: request at 0x10 accepted; assert `branch_taken` with target 0x43 before the response arrives.
  - Required: the 0x10 response is discarded, `instr_valid` stays 0, and the next request is at 0x40.
- Redirect coincident with response and with handshake:
  - Stimulus: (a) `branch_taken` in the same cycle as `imem_rsp_valid`; (b) `branch_taken` in the same cycle as a request handshake.
  - Required: in both cases that fetch never reaches `instr`, and the next request address is the target.
- Wrap and reset mid-operation:
  - Stimulus: `RESET_PC = 32'hFFFF_FFFC`; then assert `rst_n = 0` while in WAIT.
  - Required: the second request is at 0x0 and `pc_plus4` wraps to 0. After the reset, all outputs take their reset values and the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch.sv
// Sequential instruction-fetch front end: owns the PC, issues one word request
// at a time to instruction memory and holds the returned instruction for decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  logic req_valid;
  logic handshake;
  logic consume;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    req_valid = rst_n && (state_q == S_FETCH) && (!instr_valid_q || !stall);
    handshake = req_valid && imem_req_ready;
    consume   = instr_valid_q && !stall;

    if (consume) begin
      instr_valid_d = 1'b0;
    end

    case (state_q)
      S_FETCH: begin
        if (handshake) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          // The request still goes out at the old PC; its response must be dropped.
          state_d  = branch_taken ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_FETCH;
          if (!branch_taken) begin
            instr_d       = imem_rsp_data;
            instr_pc_d    = req_pc_q;
            instr_valid_d = 1'b1;
          end
        end else if (branch_taken) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rsp_valid) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (branch_taken) begin
      pc_d          = branch_target & ~32'h3;
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous; every register here is plain state (no
    // memory arrays), so each one is given a defined reset value.
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      req_pc_q      <= 32'h0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[31:26];
  assign instr_pc       = instr_pc_q;
  assign pc_plus4       = instr_pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory responses are driven step by step
// with hand-computed expectations; a second instance covers PC wrap.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;

  logic        req_valid, instr_valid;
  logic [31:0] req_addr, instr, instr_pc, pc_plus4;
  logic [5:0]  opcode;

  logic        w_req_valid, w_instr_valid;
  logic [31:0] w_req_addr, w_instr, w_instr_pc, w_pc_plus4;
  logic [5:0]  w_opcode;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .opcode         (opcode),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst2_n),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall          (stall),
    .instr_valid    (w_instr_valid),
    .instr          (w_instr),
    .opcode         (w_opcode),
    .instr_pc       (w_instr_pc),
    .pc_plus4       (w_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch through a 1-cycle memory; ends in the cycle the word is held.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input string tag);
    imem_req_ready = 1'b1;
    #1;
    check({tag, "_req_valid"}, 32'(req_valid), 32'd1);
    check({tag, "_req_addr"}, req_addr, addr);
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    #1;
    check({tag, "_wait_req"}, 32'(req_valid), 32'd0);
    check({tag, "_wait_iv"}, 32'(instr_valid), 32'd0);
    cyc();
    imem_rsp_valid = 1'b0;
    #1;
    check({tag, "_iv"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instr, data);
    check({tag, "_instr_pc"}, instr_pc, addr);
    check({tag, "_pc_plus4"}, pc_plus4, addr + 32'd4);
  endtask

  initial begin
    rst_n          = 1'b0;
    rst2_n         = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    branch_taken   = 1'b0;
    branch_target  = 32'h0;
    stall          = 1'b0;
    cyc();
    cyc();

    // Reset values
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_iv", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'd4);

    // Sequential fetch
    rst_n = 1'b1;
    fetch(32'h0, 32'h8C01_0004, "seq0");
    check("seq0_opcode", 32'(opcode), 32'h23);
    fetch(32'h4, 32'h0022_1820, "seq1");
    check("seq1_opcode", 32'(opcode), 32'h00);
    fetch(32'h8, 32'h1000_FFFF, "seq2");
    check("seq2_opcode", 32'(opcode), 32'h04);

    // Memory not ready for 3 cycles: request held stable
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nr_req_valid", 32'(req_valid), 32'd1);
      check("nr_req_addr", req_addr, 32'hC);
      cyc();
    end
    fetch(32'hC, 32'hAC22_0008, "bp0");

    // Downstream stall for 4 cycles: instruction held, no request
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("st_req_valid", 32'(req_valid), 32'd0);
      check("st_iv", 32'(instr_valid), 32'd1);
      check("st_instr", instr, 32'hAC22_0008);
      check("st_instr_pc", instr_pc, 32'hC);
      cyc();
    end
    stall = 1'b0;
    fetch(32'h10, 32'h2042_0001, "bp1");

    // Redirect in FETCH without handshake
    branch_taken  = 1'b1;
    branch_target = 32'h13;
    cyc();
    branch_taken = 1'b0;
    #1;
    check("rf_iv", 32'(instr_valid), 32'd0);
    check("rf_req_valid", 32'(req_valid), 32'd1);
    check("rf_req_addr", req_addr, 32'h10);

    // Redirect in WAIT before the response
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    branch_taken   = 1'b1;
    branch_target  = 32'h43;
    #1;
    check("rw_wait_req", 32'(req_valid), 32'd0);
    cyc();
    branch_taken = 1'b0;
    #1;
    check("rw_disc_req", 32'(req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    cyc();
    imem_rsp_valid = 1'b0;
    #1;
    check("rw_iv", 32'(instr_valid), 32'd0);
    check("rw_req_valid", 32'(req_valid), 32'd1);
    check("rw_req_addr", req_addr, 32'h40);

    // Redirect coincident with the response
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0001;
    branch_taken   = 1'b1;
    branch_target  = 32'h80;
    cyc();
    imem_rsp_valid = 1'b0;
    branch_taken   = 1'b0;
    #1;
    check("rr_iv", 32'(instr_valid), 32'd0);
    check("rr_instr", instr, 32'h2042_0001);
    check("rr_req_valid", 32'(req_valid), 32'd1);
    check("rr_req_addr", req_addr, 32'h80);

    // Redirect coincident with a handshake
    imem_req_ready = 1'b1;
    branch_taken   = 1'b1;
    branch_target  = 32'h200;
    #1;
    check("rh_req_valid", 32'(req_valid), 32'd1);
    check("rh_req_addr", req_addr, 32'h80);
    cyc();
    imem_req_ready = 1'b0;
    branch_taken   = 1'b0;
    #1;
    check("rh_disc_req", 32'(req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0002;
    cyc();
    imem_rsp_valid = 1'b0;
    #1;
    check("rh_iv", 32'(instr_valid), 32'd0);
    check("rh_req_addr", req_addr, 32'h200);
    fetch(32'h200, 32'h0800_0010, "rh_next");
    check("rh_next_opcode", 32'(opcode), 32'h02);

    // Wrap instance: hold the first DUT in reset and release the second
    rst_n = 1'b0;
    cyc();
    #1;
    check("rst2_iv", 32'(instr_valid), 32'd0);
    check("rst2_instr_pc", instr_pc, 32'h0);
    check("w_rst_pc_plus4", w_pc_plus4, 32'd4);
    check("w_rst_req_valid", 32'(w_req_valid), 32'd0);
    rst2_n         = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    check("w_req_valid0", 32'(w_req_valid), 32'd1);
    check("w_req_addr0", w_req_addr, 32'hFFFF_FFFC);
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2408_0001;
    cyc();
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    check("w_iv", 32'(w_instr_valid), 32'd1);
    check("w_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    check("w_pc_plus4", w_pc_plus4, 32'h0);
    check("w_opcode", 32'(w_opcode), 32'h09);
    check("w_req_addr1", w_req_addr, 32'h0);
    cyc();

    // Reset while in WAIT, then a stray response right after release
    imem_req_ready = 1'b0;
    rst2_n         = 1'b0;
    #1;
    check("w_mid_req_valid", 32'(w_req_valid), 32'd0);
    cyc();
    #1;
    check("w_mid_iv", 32'(w_instr_valid), 32'd0);
    check("w_mid_instr", w_instr, 32'h0);
    check("w_mid_instr_pc", w_instr_pc, 32'h0);
    check("w_mid_pc_plus4", w_pc_plus4, 32'd4);
    rst2_n         = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0003;
    #1;
    check("w_rel_req_valid", 32'(w_req_valid), 32'd1);
    check("w_rel_req_addr", w_req_addr, 32'hFFFF_FFFC);
    cyc();
    imem_rsp_valid = 1'b0;
    #1;
    check("w_stray_iv", 32'(w_instr_valid), 32'd0);
    check("w_stray_instr", w_instr, 32'h0);
    check("w_hold_req_valid", 32'(w_req_valid), 32'd1);
    check("w_hold_req_addr", w_req_addr, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
